mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-stage pipeline register and data-memory access unit of the 5-stage MIPS core. Sits directly downstream of the execute stage.
- Latches the execute results (pc, ALU result/address, store data, icode, acode, dst) and runs one data-memory transaction per load/store through a valid/addr_ok/data_ok handshake.
- Aligns and extends load data, and presents the final value to the writeback stage.
- Raises m_busy so the hazard unit can freeze upstream stages while a transaction is outstanding.

Parameters:
- LW_OP, 6'h23, opcode of LW
- LB_OP / LBU_OP / LH_OP / LHU_OP, 6'h20 / 6'h24 / 6'h21 / 6'h25, byte/half load opcodes
- SW_OP / SB_OP / SH_OP, 6'h2B / 6'h28 / 6'h29, store opcodes

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- M_stall  in  1  hold pipeline register
- M_bubble  in  1  load a bubble (all zero)
- M_pc  in  32  pc from execute
- M_val3  in  32  ALU result / effective address
- M_valt  in  32  store data (rt value)
- M_icode  in  6  opcode
- M_acode  in  6  funct
- M_dst  in  5  destination register
- dreq_valid  out  1  memory request valid
- dreq_addr  out  32  request address (= latched val3)
- dreq_size  out  2  0 = byte, 1 = half, 2 = word
- dreq_strobe  out  4  byte write enables; 0 for loads
- dreq_data  out  32  store data, replicated per lane
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  response/data valid
- dresp_data  in  32  read data word
- m_pc, m_val  out  32  pc; result to writeback (load data or ALU result)
- m_icode, m_acode  out  6
- m_dst  out  5
- m_busy  out  1  transaction outstanding

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - All m_* registers go to 0; state goes to IDLE.
  - dreq_valid=0, m_busy=0, captured read data=0.
  - Reset mid-transaction abandons it immediately; dreq_valid is low the next cycle.
- Register update priority: reset > busy (state REQ or WAIT; register frozen internally) > M_stall (hold) > M_bubble (load zeros) > load inputs.
- FSM states: IDLE, REQ, WAIT, DONE.
  - Any register load: next state is REQ if the loaded icode is a load or store, else IDLE.
  - REQ: dreq_valid=1.
    - addr_ok && data_ok in the same cycle → DONE, capture dresp_data.
    - addr_ok only → WAIT.
    - neither → stay in REQ.
  - WAIT: dreq_valid=0.
    - data_ok → DONE, capture dresp_data.
    - otherwise stay in WAIT.
  - DONE / IDLE: hold until the next register load.
- m_busy = (state==REQ) || (state==WAIT), combinational.
  - The hazard unit must assert stall upstream while m_busy=1.
- Minimum latency: a load enters the M register at edge N. REQ is cycle N..N+1. With addr_ok and data_ok both high in that cycle, DONE is reached at edge N+1 and m_val is valid in cycle N+1.
- Request fields:
  - dreq_size: byte for LB/LBU/SB, half for LH/LHU/SH, word otherwise.
  - Strobe: SW 4'b1111; SH 4'b0011 << {addr[1],1'b0}; SB 4'b0001 << addr[1:0].
  - Data: SW valt; SH {2{valt[15:0]}}; SB {4{valt[7:0]}}.
- No alignment check; addr[1:0] is passed through unchanged.
- m_val:
  - Non-load: m_val = latched val3.
  - LW: captured word.
  - LB/LBU: byte at addr[1:0], sign/zero extended.
  - LH/LHU: half at addr[1], sign/zero extended.
  - Stores and bubbles: val3 (0 for a bubble).
- Response pulses arriving in IDLE or DONE are ignored.

Test Plan:
- Reset asserted with state in WAIT → next cycle dreq_valid=0, m_busy=0, every m_* output 0.
- ADDIU (icode 6'h09, val3=32'h1234) loaded, no stall → next cycle m_val=32'h1234, dreq_valid=0, m_busy=0.
- LB with val3=32'h1003; addr_ok and data_ok same cycle, dresp_data=32'h80AA_BBCC → m_val=32'hFFFF_FF80, m_busy high exactly 1 cycle. Same stimulus as LBU → m_val=32'h0000_0080.
- SH with val3=32'h2002, valt=32'h0000_BEEF; addr_ok after 2 cycles, data_ok 3 cycles later → strobe=4'b1100, data=32'hBEEF_BEEF, size=1, dreq_valid high 3 cycles, m_busy high 6 cycles.
- LW in WAIT with M_bubble and new inputs applied → register unchanged until data_ok. Next edge after DONE with M_bubble=1 → all outputs 0, state IDLE.
- M_stall held 3 cycles in DONE after LHU (data 32'h8001_0000, addr 32'h0002) → m_val stays 32'h0000_8001, no new request issued.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and the data memory.
// Ports: dreq_valid/addr/size/strobe/data (stage -> memory),
//        dresp_addr_ok/data_ok/data (memory -> stage).
interface mem_stage_if;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  // Memory-stage side: issues requests, consumes responses.
  modport master (
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data
  );

  // Data-memory side: accepts requests, returns responses.
  modport slave (
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-stage pipeline register and data-memory access unit of the 5-stage MIPS core.
// Ports: clk/reset; M_* execute results with M_stall/M_bubble pipeline control;
//        dmem (mem_stage_if.master) data-memory bus; m_* results to writeback; m_busy to hazard unit.
module mem_stage #(
  parameter logic [5:0] LW_OP  = 6'h23,
  parameter logic [5:0] LB_OP  = 6'h20,
  parameter logic [5:0] LBU_OP = 6'h24,
  parameter logic [5:0] LH_OP  = 6'h21,
  parameter logic [5:0] LHU_OP = 6'h25,
  parameter logic [5:0] SW_OP  = 6'h2B,
  parameter logic [5:0] SB_OP  = 6'h28,
  parameter logic [5:0] SH_OP  = 6'h29
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         M_stall,
  input  logic         M_bubble,
  input  logic [31:0]  M_pc,
  input  logic [31:0]  M_val3,
  input  logic [31:0]  M_valt,
  input  logic [5:0]   M_icode,
  input  logic [5:0]   M_acode,
  input  logic [4:0]   M_dst,
  mem_stage_if.master  dmem,
  output logic [31:0]  m_pc,
  output logic [31:0]  m_val,
  output logic [5:0]   m_icode,
  output logic [5:0]   m_acode,
  output logic [4:0]   m_dst,
  output logic         m_busy
);
  // Purpose: latch execute results, run one data-memory transaction per load/store, align load data.
  // Latency: register loads in 1 cycle; a memory op adds >=1 cycle (REQ->DONE when addr_ok&data_ok coincide).
  // Backpressure: m_busy is high in REQ/WAIT; the register then ignores M_stall/M_bubble/inputs.

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val3;
    logic [31:0] valt;
    logic [5:0]  icode;
    logic [5:0]  acode;
    logic [4:0]  dst;
  } m_reg_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  m_reg_t      mreg, mreg_nxt;
  logic [31:0] rdata, rdata_nxt;

  function automatic logic is_load(input logic [5:0] op);
    return (op == LW_OP) || (op == LB_OP) || (op == LBU_OP) ||
           (op == LH_OP) || (op == LHU_OP);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == SW_OP) || (op == SB_OP) || (op == SH_OP);
  endfunction

  // ---------------------------------------------------------------------------
  // State / pipeline register / captured read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      mreg  <= '0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      mreg  <= mreg_nxt;
      rdata <= rdata_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, register update and read-data capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    mreg_nxt  = mreg;
    rdata_nxt = rdata;
    case (state)
      S_REQ: begin
        // Register is frozen while the transaction is outstanding.
        if (dmem.dresp_addr_ok) begin
          if (dmem.dresp_data_ok) begin
            state_nxt = S_DONE;
            rdata_nxt = dmem.dresp_data;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (dmem.dresp_data_ok) begin
          state_nxt = S_DONE;
          rdata_nxt = dmem.dresp_data;
        end
      end
      default: begin
        // IDLE / DONE: stray response pulses are ignored here.
        if (!M_stall) begin
          if (M_bubble) begin
            mreg_nxt  = '0;
            state_nxt = S_IDLE;
          end else begin
            mreg_nxt.pc    = M_pc;
            mreg_nxt.val3  = M_val3;
            mreg_nxt.valt  = M_valt;
            mreg_nxt.icode = M_icode;
            mreg_nxt.acode = M_acode;
            mreg_nxt.dst   = M_dst;
            state_nxt = (is_load(M_icode) || is_store(M_icode)) ? S_REQ : S_IDLE;
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request fields; address low bits pass through without an alignment check
  // ---------------------------------------------------------------------------
  always_comb begin
    dmem.dreq_valid  = (state == S_REQ);
    dmem.dreq_addr   = mreg.val3;
    dmem.dreq_size   = 2'd2;
    dmem.dreq_strobe = 4'b0000;
    dmem.dreq_data   = mreg.valt;
    if (mreg.icode == LB_OP || mreg.icode == LBU_OP) begin
      dmem.dreq_size = 2'd0;
    end else if (mreg.icode == LH_OP || mreg.icode == LHU_OP) begin
      dmem.dreq_size = 2'd1;
    end else if (mreg.icode == SB_OP) begin
      dmem.dreq_size   = 2'd0;
      dmem.dreq_strobe = 4'b0001 << mreg.val3[1:0];
      dmem.dreq_data   = {4{mreg.valt[7:0]}};
    end else if (mreg.icode == SH_OP) begin
      dmem.dreq_size   = 2'd1;
      dmem.dreq_strobe = 4'b0011 << {mreg.val3[1], 1'b0};
      dmem.dreq_data   = {2{mreg.valt[15:0]}};
    end else if (mreg.icode == SW_OP) begin
      dmem.dreq_strobe = 4'b1111;
    end
  end

  // ---------------------------------------------------------------------------
  // Load alignment and writeback value
  // ---------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (mreg.val3[1:0])
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = mreg.val3[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    m_val = mreg.val3;
    if (mreg.icode == LW_OP) begin
      m_val = rdata;
    end else if (mreg.icode == LB_OP) begin
      m_val = {{24{ld_byte[7]}}, ld_byte};
    end else if (mreg.icode == LBU_OP) begin
      m_val = {24'd0, ld_byte};
    end else if (mreg.icode == LH_OP) begin
      m_val = {{16{ld_half[15]}}, ld_half};
    end else if (mreg.icode == LHU_OP) begin
      m_val = {16'd0, ld_half};
    end
  end

  assign m_pc    = mreg.pc;
  assign m_icode = mreg.icode;
  assign m_acode = mreg.acode;
  assign m_dst   = mreg.dst;
  assign m_busy  = (state == S_REQ) || (state == S_WAIT);

endmodule
